// File: rtl/sram_port_arbiter.sv
// Shares a 1W1R SRAM between an instruction-fetch reader (A) and a data port (B), with optional post-reset zero-fill.
// Read arbitration is fixed B-over-A by default; define SRAM_ARB_RR_EN for round-robin on read conflicts.
module sram_port_arbiter #(
    parameter int ADDR_WIDTH     = 11,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_WMASKS     = 4,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [NUM_WMASKS-1:0] b_wmask,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  busy,
    output logic                  sram_csb0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_fill_cnt;
    logic                  r_a_rvalid;
    logic                  r_b_rvalid;

    logic w_run;
    logic w_fill;
    logic w_b_wr;
    logic w_b_rd;
    logic w_hazard;
    logic w_a_cand;
    logic w_conflict;
    logic w_b_wins;
    logic w_a_rd_gnt;
    logic w_b_rd_gnt;
    logic w_b_wr_gnt;

    // Grants and fill writes are suppressed while rst is high so the SRAM sees an idle cycle.
    assign w_run  = (r_state == S_RUN)  && !rst;
    assign w_fill = (r_state == S_INIT) && !rst;

    assign w_b_wr = b_req &&  b_we;
    assign w_b_rd = b_req && !b_we;

    // Negedge read/write to one address in the same cycle has undefined ordering, so hold A off.
    assign w_hazard   = a_req && w_b_wr && (a_addr == b_addr);
    assign w_a_cand   = a_req && !w_hazard;
    assign w_conflict = w_a_cand && w_b_rd;

`ifdef SRAM_ARB_RR_EN
    logic r_rr_last_b;

    assign w_b_wins = !r_rr_last_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last_b <= 1'b0;
        end else if (w_run && w_conflict) begin
            r_rr_last_b <= w_b_wins;
        end
    end
`else
    assign w_b_wins = 1'b1;
`endif

    assign w_a_rd_gnt = w_run && w_a_cand && !(w_conflict &&  w_b_wins);
    assign w_b_rd_gnt = w_run && w_b_rd   && !(w_conflict && !w_b_wins);
    assign w_b_wr_gnt = w_run && w_b_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_INIT: begin
                if (r_fill_cnt == {ADDR_WIDTH{1'b1}}) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_RUN;
        endcase
    end

    always_comb begin
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;
        busy        = (r_state == S_INIT);
        sram_csb0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        sram_csb1   = 1'b1;
        sram_addr1  = '0;
        case (r_state)
            S_INIT: begin
                if (w_fill) begin
                    sram_csb0   = 1'b0;
                    sram_wmask0 = '1;
                    sram_addr0  = r_fill_cnt;
                end
            end
            S_RUN: begin
                a_gnt = w_a_rd_gnt;
                b_gnt = w_b_rd_gnt || w_b_wr_gnt;
                if (w_b_wr_gnt) begin
                    sram_csb0   = 1'b0;
                    sram_wmask0 = b_wmask;
                    sram_addr0  = b_addr;
                    sram_din0   = b_wdata;
                end
                if (w_b_rd_gnt) begin
                    sram_csb1  = 1'b0;
                    sram_addr1 = b_addr;
                end else if (w_a_rd_gnt) begin
                    sram_csb1  = 1'b0;
                    sram_addr1 = a_addr;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_cnt <= '0;
        end else if (r_state == S_INIT) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
        end
    end

    // The macro returns data one cycle after the address is registered, so valid is the delayed grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= w_a_rd_gnt;
            r_b_rvalid <= w_b_rd_gnt;
        end
    end

    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign a_rdata  = sram_dout1;
    assign b_rdata  = sram_dout1;

endmodule
